// File: rtl/obi_addr_demux.sv
// obi_addr_demux: address-decoding OBI demultiplexer, one manager to NumSbr
// mapped subordinates plus an error port at index NumSbr.
//
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   mgr_req_i     request from the upstream manager
//   mgr_rsp_o     response to the upstream manager
//   sbr_req_o     requests to subordinates, [NumSbr] = error port
//   sbr_rsp_i     responses from subordinates
//   err_cnt_o     saturating count of requests accepted by the error port
//                 (only when OBI_ADDR_DEMUX_ERR_CNT_EN is defined)

package obi_pkg;

    localparam int unsigned ObiAddrWidth = 32;
    localparam int unsigned ObiDataWidth = 32;

    typedef struct packed {
        logic        UseRReady;
        int unsigned AddrWidth;
        int unsigned DataWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        UseRReady: 1'b0,
        AddrWidth: ObiAddrWidth,
        DataWidth: ObiDataWidth
    };

    typedef struct packed {
        logic [ObiAddrWidth-1:0]   addr;
        logic                      we;
        logic [ObiDataWidth/8-1:0] be;
        logic [ObiDataWidth-1:0]   wdata;
    } obi_a_chan_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
        logic        rready;
    } obi_req_t;

    typedef struct packed {
        logic [ObiDataWidth-1:0] rdata;
        logic                    err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

endpackage

module obi_addr_demux #(
    parameter obi_pkg::obi_cfg_t ObiCfg      = obi_pkg::ObiDefaultConfig,
    parameter type               obi_req_t   = obi_pkg::obi_req_t,
    parameter type               obi_rsp_t   = obi_pkg::obi_rsp_t,
    parameter int unsigned       NumSbr      = 2,
    parameter int unsigned       NumMaxTrans = 4,
    parameter logic [NumSbr-1:0][obi_pkg::ObiAddrWidth-1:0] AddrBase =
        {32'h1000_0000, 32'h0000_0000},
    parameter logic [NumSbr-1:0][obi_pkg::ObiAddrWidth-1:0] AddrMask =
        {32'hF000_0000, 32'hF000_0000}
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  obi_req_t mgr_req_i,
    output obi_rsp_t mgr_rsp_o,
    output obi_req_t sbr_req_o [NumSbr:0],
    input  obi_rsp_t sbr_rsp_i [NumSbr:0]
`ifdef OBI_ADDR_DEMUX_ERR_CNT_EN
    ,
    output logic [15:0] err_cnt_o
`endif
);

    localparam int unsigned     CntW   = $clog2(NumMaxTrans + 1);
    localparam int unsigned     SelW   = $clog2(NumSbr + 1);
    localparam logic [SelW-1:0] ErrSel = SelW'(NumSbr);

    logic [CntW-1:0] r_cnt;
    logic [SelW-1:0] r_last_sel;
    logic [SelW-1:0] w_sel;
    logic            w_stall;
    logic            w_gnt;
    logic            w_accept;
    logic            w_retire;

    // Scan downwards so the lowest matching port is the final winner.
    always_comb begin
        w_sel = ErrSel;
        for (int i = int'(NumSbr) - 1; i >= 0; i--) begin
            if ((mgr_req_i.a.addr & AddrMask[i]) == AddrBase[i]) begin
                w_sel = SelW'(i);
            end
        end
    end

    // Responses come back in order only while every outstanding
    // transaction targets the same port, so a port switch waits for idle.
    assign w_stall = (r_cnt == CntW'(NumMaxTrans))
                  || ((r_cnt != '0) && (w_sel != r_last_sel));

    assign w_gnt = sbr_rsp_i[w_sel].gnt && !w_stall && !rst_i;

    always_comb begin
        for (int i = 0; i <= int'(NumSbr); i++) begin
            sbr_req_o[i]     = mgr_req_i;
            sbr_req_o[i].req = (SelW'(i) == w_sel) && mgr_req_i.req
                            && !w_stall && !rst_i;
            if (ObiCfg.UseRReady && (SelW'(i) != r_last_sel)) begin
                sbr_req_o[i].rready = 1'b1;
            end else if (!ObiCfg.UseRReady) begin
                sbr_req_o[i].rready = 1'b1;
            end
        end
    end

    always_comb begin
        mgr_rsp_o        = '0;
        mgr_rsp_o.gnt    = w_gnt;
        mgr_rsp_o.rvalid = sbr_rsp_i[r_last_sel].rvalid;
        mgr_rsp_o.r      = sbr_rsp_i[r_last_sel].r;
    end

    assign w_accept = mgr_req_i.req && w_gnt;
    assign w_retire = mgr_rsp_o.rvalid
                   && (mgr_req_i.rready || !ObiCfg.UseRReady);

    // A retire with nothing outstanding is a protocol error; hold at zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_last_sel <= '0;
        end else begin
            if (w_accept) begin
                r_last_sel <= w_sel;
            end
            if (w_accept && !w_retire) begin
                r_cnt <= r_cnt + CntW'(1);
            end else if (!w_accept && w_retire && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CntW'(1);
            end
        end
    end

`ifdef OBI_ADDR_DEMUX_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err_cnt <= '0;
        end else if (w_accept && (w_sel == ErrSel)
                     && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt_o = r_err_cnt;
`endif

endmodule

// File: doc/obi_addr_demux.md
Name: obi_addr_demux

Overview:
Address-decoding OBI demultiplexer: one manager port fans out to NumSbr mapped subordinate ports plus one dedicated error port at index NumSbr. The error port is wired directly to the team's error subordinate, so any unmapped access completes with err=1. Tracks outstanding transactions so in-order OBI responses are routed back from the correct port, and stalls any request that would reorder responses.

Parameters:
ObiCfg, obi_pkg::ObiDefaultConfig, OBI configuration shared by all ports
obi_req_t, logic, OBI request struct type
obi_rsp_t, logic, OBI response struct type
NumSbr, 2, number of mapped subordinate ports (>=1); total ports NumSbr+1
NumMaxTrans, 4, maximum outstanding transactions (>=1)
AddrBase, {32'h1000_0000, 32'h0000_0000}, per-port base address, [NumSbr-1:0] x AddrWidth, index 0 rightmost
AddrMask, {32'hF000_0000, 32'hF000_0000}, per-port compare mask, same shape

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active-high
mgr_req_i  input  obi_req_t  request from upstream manager
mgr_rsp_o  output  obi_rsp_t  response to upstream manager
sbr_req_o  output  [NumSbr:0] obi_req_t  requests to subordinates; index NumSbr = error port
sbr_rsp_i  input  [NumSbr:0] obi_rsp_t  responses from subordinates

Behaviour:
- Decode (combinational): port i matches when (a.addr & AddrMask[i]) == AddrBase[i]. Lowest matching index wins. No match -> sel = NumSbr (error port).
- State: cnt, width $clog2(NumMaxTrans+1), reset 0. last_sel, width $clog2(NumSbr+1), reset 0. Both reset asynchronously on rst_i.
- stall = (cnt == NumMaxTrans) || (cnt != 0 && sel != last_sel).
- Request path, zero latency:
  - a-channel fields are broadcast to all sbr_req_o.
  - sbr_req_o[sel].req = mgr_req_i.req && !stall; every other port's req = 0.
  - mgr_rsp_o.gnt = sbr_rsp_i[sel].gnt && !stall.
- Accept = mgr_req_i.req && mgr_rsp_o.gnt. On accept, last_sel <= sel.
- Response path, combinational from last_sel:
  - mgr_rsp_o.r and mgr_rsp_o.rvalid are taken from sbr_rsp_i[last_sel].
  - If ObiCfg.UseRReady: rready is forwarded only to port last_sel; all others get 1'b1.
- Retire = mgr_rsp_o.rvalid && (rready || !ObiCfg.UseRReady).
- Counter update:
  - accept only -> cnt+1
  - retire only -> cnt-1
  - accept and retire in the same cycle -> cnt unchanged, last_sel updated
  - neither -> hold
- Boundaries:
  - cnt == NumMaxTrans: gnt forced 0, even if the target port would grant.
  - Retire at cnt == NumMaxTrans frees the slot the following cycle only; no same-cycle bypass.
  - Switching target port: stalled until cnt returns to 0, then granted.
  - Retire at cnt == 0 is a protocol violation; cnt must not underflow (holds 0).
- Reset while active (rst_i high): gnt and all sbr req are forced 0. In-flight responses are dropped; cnt=0 and last_sel=0 after release.
- Manager must hold a-channel stable while req is high and ungranted; the block re-decodes every cycle.

Optional Feature:
Macro OBI_ADDR_DEMUX_ERR_CNT_EN.
- Defined: extra output err_cnt_o, 16 bits. Saturating counter, incremented once per accepted request with sel == NumSbr. Holds at 16'hFFFF. Async reset to 0 on rst_i.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Map defaults, addr 0x0000_0040 read -> port 0 req=1, gnt back, rvalid from port 0; addr 0x1000_0000 after retire -> port 1; cnt back to 0.
- addr 0x2000_0000 -> error port req=1; error subordinate returns rdata 0xBADCAB1E, err=1 on mgr_rsp_o; err_cnt_o == 1 with macro defined.
- Issue to port 0 (response delayed 5 cycles), then request to port 1 -> gnt held 0 until port 0 rvalid retires; port 1 granted the next cycle.
- NumMaxTrans=4, subordinate always grants, responses held off -> 4 accepts, 5th req sees gnt=0; one retire -> 5th granted the following cycle.
- UseRReady=1, rvalid held with rready=0 for 3 cycles then rready=1 in the same cycle as a new accept to the same port -> cnt unchanged, response delivered once.
- Assert rst_i with cnt=3 -> gnt=0 and all sbr req=0 immediately; after release cnt=0, a new request to port 1 is granted without stall.
